// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared constants and helpers for the serial-to-parallel deserializer
//
// Holds the default word width, the derived bit-counter width and the
// bit-order selector values used by sipo_shift_reg and sipo_deserializer.
package sipo_pkg;

    localparam int DEFAULT_WIDTH   = 8;

    // Bit-order selector values for the MSB_FIRST parameter.
    localparam int MSB_FIRST_ORDER = 1;
    localparam int LSB_FIRST_ORDER = 0;

    // Counter width for the default word width.
    localparam int CNT_W           = $clog2(DEFAULT_WIDTH);

    // Counter width for an arbitrary word width; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// rtl/sipo_shift_reg.sv - bit counter and shift register assembling serial bits into words
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset, clears counter and shift register
//   din        serial data bit
//   din_valid  din is accepted on this edge
//   align      discard any partial word; a bit accepted on the same edge starts a new word
//   word       the shift-register contents including the bit being accepted this cycle
//   word_done  high in the cycle whose accepted bit completes a word; word is then complete
module sipo_shift_reg
    import sipo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = MSB_FIRST_ORDER
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             din_valid,
    input  logic             align,
    output logic [WIDTH-1:0] word,
    output logic             word_done
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_base;
    logic [CW-1:0]    cnt_next;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_base;
    logic [WIDTH-1:0] sr_next;

    // align acts as if the counter and register were already empty, so a bit
    // arriving together with align lands as the first bit of a fresh word.
    always_comb begin
        cnt_base = align ? '0 : cnt_q;
        sr_base  = align ? '0 : sr_q;

        if (MSB_FIRST != 0) begin
            // Shift toward the MSB: after WIDTH bits the first one sits in WIDTH-1.
            sr_next = {sr_base[WIDTH-2:0], din};
        end else begin
            // Shift toward the LSB: after WIDTH bits the first one sits in bit 0.
            sr_next = {din, sr_base[WIDTH-1:1]};
        end

        word_done = din_valid && (cnt_base == LAST_BIT);
        cnt_next  = word_done ? '0 : cnt_base + CW'(1);
        word      = sr_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            sr_q  <= '0;
        end else if (din_valid) begin
            cnt_q <= cnt_next;
            sr_q  <= sr_next;
        end else if (align) begin
            cnt_q <= '0;
            sr_q  <= '0;
        end
    end

endmodule

// File: rtl/sipo_deserializer.sv
// rtl/sipo_deserializer.sv - serial-in parallel-out deserializer with valid/ready output and overrun flag
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   din        serial data bit from the upstream flip-flop stage
//   din_valid  qualifies din; every valid bit is accepted (no serial back-pressure)
//   align      discards any partial word; does not touch the output handshake
//   out_ready  downstream accepts out_data this cycle
//   out_data   assembled word, held stable while out_valid=1 and out_ready=0
//   out_valid  out_data holds an unconsumed word
//   overrun    one-cycle pulse when a completed word is dropped
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = MSB_FIRST_ORDER
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             din_valid,
    input  logic             align,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             overrun
);

    logic [WIDTH-1:0] word;
    logic             word_done;

    sipo_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_reg (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .align     (align),
        .word      (word),
        .word_done (word_done)
    );

    // A completed word may be loaded when the output slot is empty or is being
    // emptied on this same edge; the latter keeps out_valid high with no bubble.
    // Otherwise the new word is dropped and the held word stays untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (word_done) begin
                if (!out_valid || out_ready) begin
                    out_data  <= word;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb/tb_sipo_deserializer.sv - self-checking bench for sipo_deserializer in both bit orders
module tb_sipo_deserializer;

    logic       clk;
    logic       reset;
    logic       din;
    logic       din_valid;
    logic       align;
    logic       out_ready;
    logic [7:0] msb_data;
    logic       msb_valid;
    logic       msb_ovr;
    logic [7:0] lsb_data;
    logic       lsb_valid;
    logic       lsb_ovr;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: bits of the partial word in arrival order, plus
    // the expected output slot.
    int         m_bits[$];
    logic       m_valid;
    logic       m_ovr;
    logic [7:0] m_msb;
    logic [7:0] m_lsb;
    logic [7:0] delivered[$];

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1)) dut_msb (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .align     (align),
        .out_ready (out_ready),
        .out_data  (msb_data),
        .out_valid (msb_valid),
        .overrun   (msb_ovr)
    );

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .align     (align),
        .out_ready (out_ready),
        .out_data  (lsb_data),
        .out_valid (lsb_valid),
        .overrun   (lsb_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model across the edge, compare.
    task automatic step(input logic r, input logic a, input logic dv, input logic d, input logic rdy);
        logic [7:0] wm;
        logic [7:0] wl;
        bit         xfer;
        reset     = r;
        align     = a;
        din_valid = dv;
        din       = d;
        out_ready = rdy;
        if (!r && msb_valid && rdy) delivered.push_back(msb_data);
        @(posedge clk);
        if (r) begin
            m_bits.delete();
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            m_msb   = 8'h00;
            m_lsb   = 8'h00;
        end else begin
            xfer  = m_valid && rdy;
            m_ovr = 1'b0;
            if (a) m_bits.delete();
            if (dv) m_bits.push_back(int'(d));
            if (m_bits.size() == 8) begin
                wm = 8'h00;
                wl = 8'h00;
                for (int i = 0; i < 8; i++) begin
                    wm = wm + 8'(m_bits[i] << (7 - i));
                    wl = wl + 8'(m_bits[i] << i);
                end
                m_bits.delete();
                if (!m_valid || rdy) begin
                    m_msb   = wm;
                    m_lsb   = wl;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (xfer) begin
                m_valid = 1'b0;
            end
        end
        #1;
        check("msb_valid", 32'(msb_valid), 32'(m_valid));
        check("msb_ovr",   32'(msb_ovr),   32'(m_ovr));
        check("lsb_valid", 32'(lsb_valid), 32'(m_valid));
        check("lsb_ovr",   32'(lsb_ovr),   32'(m_ovr));
        if (m_valid || r) begin
            check("msb_data", 32'(msb_data), 32'(m_msb));
            check("lsb_data", 32'(lsb_data), 32'(m_lsb));
        end
    endtask

    // Send v as eight consecutive bits, v[7] first.
    task automatic send_byte(input logic [7:0] v, input logic rdy);
        for (int i = 7; i >= 0; i--) step(1'b0, 1'b0, 1'b1, v[i], rdy);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, 1'b0, 1'b0, rdy);
    endtask

    initial begin
        logic [7:0] v;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_msb   = 8'h00;
        m_lsb   = 8'h00;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        check("rst_valid", 32'(msb_valid), 32'd0);
        check("rst_data",  32'(msb_data),  32'd0);
        check("rst_ovr",   32'(msb_ovr),   32'd0);

        // 1,0,1,0,0,1,0,1 reads 0xA5 in either order; valid for one cycle
        send_byte(8'hA5, 1'b1);
        check("a5_msb_data", 32'(msb_data), 32'hA5);
        check("a5_lsb_data", 32'(lsb_data), 32'hA5);
        check("a5_valid",    32'(msb_valid), 32'd1);
        idle(1'b1);
        check("a5_valid_drop", 32'(msb_valid), 32'd0);

        // 1,1,0,0,0,0,0,0 -> 0x03 LSB-first, 0xC0 MSB-first
        send_byte(8'hC0, 1'b1);
        check("c0_lsb_data", 32'(lsb_data), 32'h03);
        check("c0_msb_data", 32'(msb_data), 32'hC0);
        idle(1'b1);

        // Overrun: second word dropped while the first is held
        delivered.delete();
        send_byte(8'h3C, 1'b0);
        send_byte(8'hC3, 1'b0);
        check("ovr_pulse",     32'(msb_ovr),  32'd1);
        check("ovr_hold_data", 32'(msb_data), 32'h3C);
        idle(1'b0);
        check("ovr_one_cycle", 32'(msb_ovr),  32'd0);
        check("ovr_still_3c",  32'(msb_data), 32'h3C);
        idle(1'b1);
        idle(1'b1);
        check("ovr_n_deliv", 32'(delivered.size()), 32'd1);
        if (delivered.size() > 0) check("ovr_deliv0", 32'(delivered[0]), 32'h3C);

        // No bubble: completion on the same edge as a transfer
        send_byte(8'h11, 1'b0);
        v = 8'h22;
        for (int i = 7; i >= 1; i--) step(1'b0, 1'b0, 1'b1, v[i], 1'b0);
        step(1'b0, 1'b0, 1'b1, v[0], 1'b1);
        check("nobubble_valid", 32'(msb_valid), 32'd1);
        check("nobubble_data",  32'(msb_data),  32'h22);
        idle(1'b1);

        // Back-to-back words with ready held
        delivered.delete();
        send_byte(8'h5A, 1'b1);
        send_byte(8'h96, 1'b1);
        idle(1'b1);
        check("b2b_n_deliv", 32'(delivered.size()), 32'd2);
        if (delivered.size() > 1) begin
            check("b2b_deliv0", 32'(delivered[0]), 32'h5A);
            check("b2b_deliv1", 32'(delivered[1]), 32'h96);
        end

        // Align discards a partial word
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        send_byte(8'h81, 1'b1);
        check("align_data", 32'(msb_data), 32'h81);
        idle(1'b1);

        // Align together with a bit: that bit starts the new word
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        v = 8'h7E;
        step(1'b0, 1'b1, 1'b1, v[7], 1'b1);
        for (int i = 6; i >= 0; i--) step(1'b0, 1'b0, 1'b1, v[i], 1'b1);
        check("align_bit_data", 32'(msb_data), 32'h7E);
        idle(1'b1);

        // Reset mid-word with a pending word and a bit on the reset edge
        send_byte(8'h55, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("rst_mid_valid", 32'(msb_valid), 32'd0);
        check("rst_mid_data",  32'(msb_data),  32'd0);
        check("rst_mid_ovr",   32'(msb_ovr),   32'd0);
        send_byte(8'hFF, 1'b1);
        check("rst_ff_data",  32'(msb_data),  32'hFF);
        check("rst_ff_valid", 32'(msb_valid), 32'd1);
        idle(1'b1);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 9) < 7),
                 1'($urandom),
                 ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
